// File: rtl/uart_tx_framer.sv
// UART transmit frame sequencer: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Each line bit is advanced by baud_tick; parity comes from an external combinational generator.
module uart_tx_framer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    output logic [DATA_W-1:0] par_data,
    output logic [1:0]        par_type,
    input  logic              par_bit,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int CNT_W = $clog2(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] shift;
    logic [1:0]        type_q;
    logic              stop2_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop_cnt;

    logic par_en;
    assign par_en = (type_q == 2'b01) || (type_q == 2'b10);

    // NOTE: every register here is state, so all assignments are non-blocking; the reset
    // covers the data path too because par_data/par_type must read zero after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold       <= '0;
            shift      <= '0;
            type_q     <= 2'b00;
            stop2_q    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (tx_valid) begin
                        hold    <= tx_data;
                        shift   <= tx_data;
                        type_q  <= parity_type;
                        stop2_q <= stop_bits;
                        state   <= LOAD;
                    end
                end
                LOAD: if (baud_tick) begin
                    tx_out <= 1'b0;
                    state  <= START;
                end
                START: if (baud_tick) begin
                    tx_out  <= shift[0];
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: if (baud_tick) begin
                    shift <= shift >> 1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        // The registered line bit doubles as the latched parity bit.
                        if (par_en) begin
                            tx_out <= par_bit;
                            state  <= PARITY;
                        end else begin
                            tx_out <= 1'b1;
                            state  <= STOP;
                        end
                    end else begin
                        tx_out  <= shift[1];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: if (baud_tick) begin
                    tx_out   <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= STOP;
                end
                STOP: if (baud_tick) begin
                    tx_out <= 1'b1;
                    if (stop_cnt == stop2_q) begin
                        stop_cnt   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign par_data = hold;
    assign par_type = type_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: randomized frames compared bit-by-bit against
// a frame model built from the line protocol (start, data LSB first, parity, stops).
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic [7:0] par_data;
    logic [1:0] par_type;
    logic       par_bit;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tick_period = 16;
    int tick_cnt = 0;
    int done_pulses = 0;
    int frames_done = 0;
    logic [7:0] last_d = 8'h00;
    logic [1:0] last_pt = 2'b00;

    uart_tx_framer #(.DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_tick  (baud_tick),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_type(parity_type),
        .stop_bits  (stop_bits),
        .par_data   (par_data),
        .par_type   (par_type),
        .par_bit    (par_bit),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Stand-in for the shared parity generator.
    assign par_bit = (par_type == 2'b01) ? ~(^par_data) :
                     (par_type == 2'b10) ?  (^par_data) : 1'b0;

    always #5 clk = ~clk;

    // Free-running baud strobe, updated shortly after each rising edge.
    initial baud_tick = 1'b0;
    always @(posedge clk) begin
        cyc++;
        #2;
        if (tick_cnt >= tick_period - 1) begin
            tick_cnt  = 0;
            baud_tick = 1'b1;
        end else begin
            tick_cnt++;
            baud_tick = 1'b0;
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic run_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                             input bit keep_valid, input bit scramble, input bit align);
        logic exp_bits[$];
        int ones, idx, guard, load_cycles, c_start, n_bits, limit;
        bit bad_ready, bad_done, bad_par;
        ones = $countones(d);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pt == 2'b10) exp_bits.push_back(ones % 2 == 1);
        if (pt == 2'b01) exp_bits.push_back(ones % 2 == 0);
        exp_bits.push_back(1'b1);
        if (sb) exp_bits.push_back(1'b1);
        n_bits = exp_bits.size();

        guard = 0;
        while ((tx_ready !== 1'b1 || (align && baud_tick !== 1'b1)) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: tx_ready=%b, required 1", tx_ready);
            return;
        end
        tx_data     = d;
        parity_type = pt;
        stop_bits   = sb;
        tx_valid    = 1'b1;
        @(negedge clk);
        if (!keep_valid) tx_valid = 1'b0;

        idx = -1; load_cycles = 0; c_start = 0; guard = 0;
        bad_ready = 0; bad_done = 0; bad_par = 0;
        limit = (n_bits + 2) * tick_period + 10;
        while (idx < n_bits && guard < limit) begin
            if (tx_ready !== 1'b0 || busy !== 1'b1) bad_ready = 1;
            if (frame_done !== 1'b0) bad_done = 1;
            if (par_data !== d || par_type !== pt) bad_par = 1;
            if (idx < 0) load_cycles++;
            if (baud_tick === 1'b1) begin
                checks++;
                if (idx < 0) begin
                    if (tx_out !== 1'b1) begin
                        errors++;
                        $display("FAIL load_line: tx_out=%b, required 1", tx_out);
                    end
                    c_start = cyc + 1;
                end else if (tx_out !== exp_bits[idx]) begin
                    errors++;
                    $display("FAIL line_bit[%0d] data=%h type=%b: tx_out=%b, required %b",
                             idx, d, pt, tx_out, exp_bits[idx]);
                end
                idx++;
            end
            if (scramble) begin
                tx_data     = 8'($urandom);
                parity_type = 2'($urandom);
                stop_bits   = 1'($urandom);
            end
            @(negedge clk);
            guard++;
        end

        checks++;
        if (idx < n_bits) begin
            errors++;
            $display("FAIL frame_timeout: bits seen=%0d, required %0d", idx, n_bits);
        end
        checks++;
        if (load_cycles < 1 || load_cycles > tick_period || (align && load_cycles != tick_period)) begin
            errors++;
            $display("FAIL load_length: %0d cycles, required %0d", load_cycles, tick_period);
        end
        checks++;
        if (frame_done !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL frame_end: done=%b ready=%b busy=%b tx_out=%b, required 1 1 0 1",
                     frame_done, tx_ready, busy, tx_out);
        end
        checks++;
        if (cyc - c_start != n_bits * tick_period) begin
            errors++;
            $display("FAIL frame_duration: %0d clks, required %0d", cyc - c_start, n_bits * tick_period);
        end
        checks++;
        if (bad_ready) begin
            errors++;
            $display("FAIL ready_busy_in_frame: ready/busy left 0/1 mid-frame, required 0/1 throughout");
        end
        checks++;
        if (bad_done) begin
            errors++;
            $display("FAIL early_done: frame_done=1 mid-frame, required 0");
        end
        checks++;
        if (bad_par) begin
            errors++;
            $display("FAIL par_outputs: par_data=%h par_type=%b, required %h %b", par_data, par_type, d, pt);
        end
        frames_done++;
        last_d  = d;
        last_pt = pt;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        parity_type = 2'b01;
        stop_bits   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: tx_out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx_out, tx_ready, busy, frame_done);
        end
        checks++;
        if (par_data !== 8'h00 || par_type !== 2'b00) begin
            errors++;
            $display("FAIL reset_par: par_data=%h par_type=%b, required 00 00", par_data, par_type);
        end
        tx_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        tick_period = 16;
        run_frame(8'h55, 2'b10, 1'b0, 0, 0, 0);
        run_frame(8'h55, 2'b01, 1'b0, 0, 0, 0);
        tick_period = 5;
        run_frame(8'h07, 2'b10, 1'b0, 0, 0, 1);
        run_frame(8'h07, 2'b01, 1'b0, 0, 0, 1);
        run_frame(8'hA7, 2'b11, 1'b1, 0, 0, 0);
        run_frame(8'h3C, 2'b00, 1'b0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        tick_period = 6;
        run_frame(8'h01, 2'b10, 1'b0, 1, 0, 0);
        checks++;
        if (frame_done !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handoff: done=%b ready=%b, required 1 1", frame_done, tx_ready);
        end
        run_frame(8'h80, 2'b01, 1'b1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int ticks, guard;
        bit bad;
        tick_period = 8;
        d = 8'($urandom);
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        tx_data = d; parity_type = 2'b10; stop_bits = 1'b1; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        ticks = 0; guard = 0;
        while (ticks < 5 && guard < 200) begin
            if (baud_tick === 1'b1) ticks++;
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (tx_out !== d[3] || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bit3: tx_out=%b busy=%b, required %b 1", tx_out, busy, d[3]);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: tx_out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx_out, tx_ready, busy, frame_done);
        end
        checks++;
        if (par_data !== 8'h00 || par_type !== 2'b00) begin
            errors++;
            $display("FAIL abort_par: par_data=%h par_type=%b, required 00 00", par_data, par_type);
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL after_abort: line/done/busy moved after abort, required idle 1/0/0");
        end
        last_d  = 8'h00;
        last_pt = 2'b00;
        run_frame(8'($urandom), 2'b01, 1'b0, 0, 0, 0);
    endtask

    task automatic test_idle_ticks();
        bit bad_line, bad_par;
        int seen;
        tick_period = 3;
        bad_line = 0; bad_par = 0; seen = 0;
        tx_valid = 1'b0;
        repeat (30) begin
            tx_data     = 8'($urandom);
            parity_type = 2'($urandom);
            stop_bits   = 1'($urandom);
            @(negedge clk);
            if (baud_tick === 1'b1) seen++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || frame_done !== 1'b0) bad_line = 1;
            if (par_data !== last_d || par_type !== last_pt) bad_par = 1;
        end
        checks++;
        if (bad_line || seen == 0) begin
            errors++;
            $display("FAIL idle_line: state left idle under %0d ticks, required idle", seen);
        end
        checks++;
        if (bad_par) begin
            errors++;
            $display("FAIL idle_par: par_data=%h par_type=%b, required %h %b", par_data, par_type, last_d, last_pt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            tick_period = $urandom_range(2, 10);
            run_frame(8'($urandom), 2'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom));
        end
        tick_period = 7;
        run_frame(8'($urandom), 2'b10, 1'b1, 0, 1, 0);
    endtask

    initial begin
        tx_data = 8'h00; tx_valid = 1'b0; parity_type = 2'b00; stop_bits = 1'b0; reset_n = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_ticks();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (done_pulses != frames_done) begin
            errors++;
            $display("FAIL done_pulse_count: %0d pulses, required %0d", done_pulses, frames_done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
